// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Pops narrow words from a synchronous FIFO (registered read data) and
//   packs PACK_RATIO consecutive words into one wide word on a valid/ready
//   output stream. A FLUSH pulse emits whatever partial word is held, so
//   the tail of a burst is never stranded.
//
// Ports
//   CLK         clock; all state updates on the rising edge
//   RST         asynchronous, active-high reset
//   FIFO_EMPTY  upstream FIFO empty flag
//   FIFO_DOUT   upstream FIFO read data, valid the cycle after a pop
//   FIFO_REN    upstream FIFO read enable (combinational)
//   FLUSH       single-cycle request to emit any partial word
//   OUT_VALID   output word valid
//   OUT_READY   downstream accepts the output word
//   OUT_DATA    packed word; lane 0 (LSBs) holds the oldest FIFO word
//   OUT_COUNT   number of valid lanes in OUT_DATA
//   BUSY        data held, a read in flight, or a flush pending
module fifo_word_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0]            FIFO_DOUT,
  output logic                             FIFO_REN,
  input  logic                             FLUSH,
  output logic                             OUT_VALID,
  input  logic                             OUT_READY,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] OUT_DATA,
  output logic [CNT_WIDTH-1:0]             OUT_COUNT,
  output logic                             BUSY
);

  localparam int                   SUM_W     = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(PACK_RATIO);
  localparam logic [SUM_W-1:0]     RATIO_SUM = SUM_W'(PACK_RATIO);

  // State
  logic [CNT_WIDTH-1:0]             acnt_reg;
  logic                             rd_pend_reg;
  logic                             flush_req_reg;
  logic                             out_valid_reg;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data_reg;
  logic [CNT_WIDTH-1:0]             out_count_reg;
  logic [DATA_WIDTH*PACK_RATIO-1:0] asm_flat;

  // Control
  logic                 out_free;
  logic                 asm_full;
  logic                 xfer;
  logic                 flush_ready;
  logic                 flush_empty;
  logic                 partial;
  logic                 load;
  logic [CNT_WIDTH-1:0] eff;
  logic [SUM_W-1:0]     inflight;

  assign out_free    = !out_valid_reg || OUT_READY;
  assign asm_full    = (acnt_reg == FULL_CNT);
  assign xfer        = asm_full && out_free;
  // A flush waits until any in-flight read has landed in the assembly register.
  assign flush_ready = flush_req_reg && !rd_pend_reg;
  assign flush_empty = flush_ready && (acnt_reg == '0);
  assign partial     = flush_ready && (acnt_reg != '0) && !asm_full && out_free;
  assign load        = xfer || partial;

  // Lanes vacated by a transfer this cycle are free for a new read, which
  // keeps the steady state at PACK_RATIO words per PACK_RATIO+1 cycles.
  assign eff      = xfer ? '0 : acnt_reg;
  assign inflight = {1'b0, eff} + SUM_W'(rd_pend_reg);
  assign FIFO_REN = !RST && !FIFO_EMPTY && !flush_req_reg && (inflight < RATIO_SUM);

  // Assembly lanes: each lane captures the read word when the fill count
  // points at it, and clears whenever the assembly word is handed over so
  // unused lanes of a partial word read as zero.
  generate
    for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          lane_reg <= '0;
        end else if (load) begin
          lane_reg <= '0;
        end else if (rd_pend_reg && (acnt_reg == CNT_WIDTH'(gi))) begin
          lane_reg <= FIFO_DOUT;
        end
      end

      assign asm_flat[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
    end
  endgenerate

  // Fill count, read tracking and flush request. A capture never coincides
  // with a load: a load needs no read in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acnt_reg      <= '0;
      rd_pend_reg   <= 1'b0;
      flush_req_reg <= 1'b0;
    end else begin
      rd_pend_reg <= FIFO_REN;

      if (load) begin
        acnt_reg <= '0;
      end else if (rd_pend_reg) begin
        acnt_reg <= acnt_reg + 1'b1;
      end

      // Pulses arriving while a flush is pending are absorbed by it.
      if (flush_req_reg) begin
        if (flush_empty || partial) begin
          flush_req_reg <= 1'b0;
        end
      end else if (FLUSH) begin
        flush_req_reg <= 1'b1;
      end
    end
  end

  // Output register: loads a full or partial word when free, otherwise
  // holds data/count stable until the consumer accepts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= asm_flat;
      out_count_reg <= xfer ? FULL_CNT : acnt_reg;
    end else if (out_valid_reg && OUT_READY) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign OUT_VALID = out_valid_reg;
  assign OUT_DATA  = out_data_reg;
  assign OUT_COUNT = out_count_reg;
  assign BUSY      = flush_req_reg || rd_pend_reg || (acnt_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Directed bench for fifo_word_packer (DATA_WIDTH=4, PACK_RATIO=2).
//   A small FIFO model with registered read data feeds the design; a
//   monitor records every accepted output word and counts read enables.
module tb_fifo_word_packer;
  localparam int DW = 4;
  localparam int PR = 2;
  localparam int CW = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           FIFO_EMPTY;
  logic [DW-1:0]  FIFO_DOUT = '0;
  logic           FIFO_REN;
  logic           FLUSH = 1'b0;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b0;
  logic [DW*PR-1:0] OUT_DATA;
  logic [CW-1:0]  OUT_COUNT;
  logic           BUSY;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_WIDTH(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_REN   (FIFO_REN),
    .FLUSH      (FLUSH),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_COUNT  (OUT_COUNT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // FIFO model: word appears on FIFO_DOUT the cycle after a pop.
  logic [DW-1:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign FIFO_EMPTY = (rd_ptr == wr_ptr);

  always @(posedge CLK) begin
    if (FIFO_REN && !FIFO_EMPTY) begin
      FIFO_DOUT <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  int ren_count = 0;
  int valid_count = 0;
  int first_ren = -1;
  int first_valid = -1;
  int rx_n = 0;
  int rx_data [0:31];
  int rx_cnt  [0:31];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (FIFO_REN) begin
      ren_count++;
      if (first_ren < 0) first_ren = cyc;
    end
    if (OUT_VALID) begin
      valid_count++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (OUT_VALID && OUT_READY && rx_n < 32) begin
      rx_data[rx_n] = int'(OUT_DATA);
      rx_cnt[rx_n]  = int'(OUT_COUNT);
      $display("[%0t] accepted word 0x%0h count %0d", $time, OUT_DATA, OUT_COUNT);
      rx_n++;
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  int base = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
      $display("ok %s = 0x%0h", tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fmem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic rx_word(input string tag, input int idx, input int d, input int c);
    if (idx < rx_n) begin
      check({tag, "_data"}, rx_data[idx], d);
      check({tag, "_count"}, rx_cnt[idx], c);
    end else begin
      check({tag, "_present"}, rx_n, idx + 1);
    end
  endtask

  initial begin
    // ---- Test 1: reset state, then basic packing and latency ----
    #2;
    push(4'h3); push(4'hA); push(4'h5); push(4'hC);
    OUT_READY = 1'b1;
    #1;
    check("rst_out_valid", int'(OUT_VALID), 0);
    check("rst_out_data", int'(OUT_DATA), 0);
    check("rst_out_count", int'(OUT_COUNT), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_fifo_ren", int'(FIFO_REN), 0);
    tick(2);
    check("rst_ren_held", ren_count, 0);
    RST = 1'b0;
    ren_count = 0; first_ren = -1; first_valid = -1; base = rx_n;
    tick(12);
    check("t1_words", rx_n - base, 2);
    rx_word("t1_w0", base, 'hA3, 2);
    rx_word("t1_w1", base + 1, 'hC5, 2);
    check("t1_ren_pulses", ren_count, 4);
    check("t1_latency", first_valid - first_ren, 4);
    check("t1_busy_idle", int'(BUSY), 0);

    // ---- Test 2: backpressure ----
    OUT_READY = 1'b0;
    ren_count = 0; base = rx_n;
    for (int i = 1; i <= 6; i++) push(DW'(i));
    tick(4);
    check("t2_first_valid", int'(OUT_VALID), 1);
    check("t2_first_data", int'(OUT_DATA), 'h21);
    tick(12);
    check("t2_held_valid", int'(OUT_VALID), 1);
    check("t2_held_data", int'(OUT_DATA), 'h21);
    check("t2_held_count", int'(OUT_COUNT), 2);
    check("t2_ren_stopped", ren_count, 4);
    check("t2_none_accepted", rx_n - base, 0);
    OUT_READY = 1'b1;
    tick(10);
    check("t2_words", rx_n - base, 3);
    rx_word("t2_w0", base, 'h21, 2);
    rx_word("t2_w1", base + 1, 'h43, 2);
    rx_word("t2_w2", base + 2, 'h65, 2);
    check("t2_ren_total", ren_count, 6);
    check("t2_busy_idle", int'(BUSY), 0);

    // ---- Test 3: flush of a single word, then flush while idle ----
    base = rx_n;
    push(4'h7);
    tick(4);
    check("t3_partial_busy", int'(BUSY), 1);
    check("t3_no_valid_yet", int'(OUT_VALID), 0);
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    tick(4);
    check("t3_words", rx_n - base, 1);
    rx_word("t3_w0", base, 'h07, 1);
    check("t3_busy_done", int'(BUSY), 0);

    valid_count = 0;
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    check("t3_idle_flush_busy", int'(BUSY), 1);
    tick(1);
    check("t3_idle_flush_clear", int'(BUSY), 0);
    tick(3);
    check("t3_idle_no_valid", valid_count, 0);

    // ---- Test 4: flush while a read is in flight ----
    base = rx_n; ren_count = 0;
    push(4'h9);
    tick(1);
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    push(4'hB);
    #1;
    check("t4_ren_blocked", int'(FIFO_REN), 0);
    check("t4_ren_count", ren_count, 1);
    tick(4);
    check("t4_words", rx_n - base, 1);
    rx_word("t4_w0", base, 'h09, 1);
    check("t4_ren_resumed", ren_count, 2);
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    tick(4);
    rx_word("t4_w1", base + 1, 'h0B, 1);
    check("t4_busy_done", int'(BUSY), 0);

    // ---- Test 5: FIFO empty for 20 cycles ----
    ren_count = 0; valid_count = 0;
    tick(20);
    check("t5_no_ren", ren_count, 0);
    check("t5_no_valid", valid_count, 0);

    // ---- Test 6: reset mid-operation ----
    push(4'hD); push(4'hE);
    tick(2);
    check("t6_busy_before_rst", int'(BUSY), 1);
    RST = 1'b1;
    #1;
    check("t6_rst_valid", int'(OUT_VALID), 0);
    check("t6_rst_data", int'(OUT_DATA), 0);
    check("t6_rst_count", int'(OUT_COUNT), 0);
    check("t6_rst_busy", int'(BUSY), 0);
    check("t6_rst_ren", int'(FIFO_REN), 0);
    tick(2);
    RST = 1'b0;
    base = rx_n;
    push(4'h6); push(4'h5);
    tick(8);
    check("t6_words", rx_n - base, 1);
    rx_word("t6_w0", base, 'h56, 2);
    check("t6_busy_done", int'(BUSY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the team's synchronous FIFO. It pops narrow DATA_WIDTH words through the FIFO's read port and packs PACK_RATIO consecutive words into one wide word. The wide word is presented on a valid/ready output stream. A FLUSH request emits a partially filled word, so the tail of a burst is never stranded.

Parameters:
DATA_WIDTH, 4, width of one FIFO word (one lane)
PACK_RATIO, 2, FIFO words per output word; legal range 2..8
CNT_WIDTH, 2, width of lane counters; must satisfy 2**CNT_WIDTH > PACK_RATIO

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, asynchronous, active-high
FIFO_EMPTY  input  1  upstream FIFO empty flag
FIFO_DOUT  input  DATA_WIDTH  upstream FIFO registered read data
FIFO_REN  output  1  upstream FIFO read enable (combinational)
FLUSH  input  1  single-cycle request to emit any partial word
OUT_VALID  output  1  output word valid
OUT_READY  input  1  downstream accepts word
OUT_DATA  output  DATA_WIDTH*PACK_RATIO  packed word; lane 0 = bits [DATA_WIDTH-1:0] = oldest FIFO word
OUT_COUNT  output  CNT_WIDTH  number of valid lanes in OUT_DATA (1..PACK_RATIO)
BUSY  output  1  any data held, in flight, or flush pending

Behaviour:
- FIFO read contract: FIFO_DOUT holds the popped word in the cycle after a cycle with FIFO_REN=1 and FIFO_EMPTY=0. RD_PEND flag is registered as FIFO_REN & !FIFO_EMPTY.
- State:
  - assembly register ASM holds PACK_RATIO lanes; ACNT counts filled lanes.
  - RD_PEND marks a read in flight.
  - FLUSH_REQ latches a flush request.
  - output register holds OUT_DATA, OUT_COUNT and OUT_VALID.
- Capture: when RD_PEND=1, FIFO_DOUT is written into lane ACNT, and ACNT increments on that edge.
- Transfer xfer (combinational) = ACNT==PACK_RATIO && (!OUT_VALID || OUT_READY).
  - On xfer: OUT_DATA<=ASM, OUT_COUNT<=PACK_RATIO, OUT_VALID<=1, ACNT<=0, ASM lanes cleared to 0.
- Output handshake:
  - OUT_VALID && OUT_READY without a transfer clears OUT_VALID on the next edge.
  - OUT_DATA and OUT_COUNT stay stable while OUT_VALID=1 and OUT_READY=0.
- FIFO_REN = !FIFO_EMPTY && !FLUSH_REQ && (EFF + RD_PEND < PACK_RATIO), where EFF = xfer ? 0 : ACNT.
- Invariant: ACNT + RD_PEND <= PACK_RATIO. Capture and xfer never coincide.
- Throughput: steady state is PACK_RATIO words per PACK_RATIO+1 cycles.
- Latency: from the first FIFO_REN with both words available (ratio 2):
  - captures at edges 2 and 3;
  - OUT_VALID high from cycle 4.
- Backpressure: with the output register held, ASM fills to PACK_RATIO, then FIFO_REN stays 0 until xfer.
- Flush:
  - FLUSH sets FLUSH_REQ; further FLUSH pulses while set are ignored.
  - FIFO_REN is forced 0 while FLUSH_REQ=1; an in-flight read still lands.
  - Once RD_PEND=0 with ACNT==0: FLUSH_REQ clears and no word is emitted.
  - Once RD_PEND=0 with 0<ACNT<PACK_RATIO and output free: partial transfer, OUT_COUNT=ACNT, unused lanes 0, ACNT<=0, FLUSH_REQ clears.
  - ACNT==PACK_RATIO: normal xfer first, then FLUSH_REQ clears on the following cycle.
- BUSY = FLUSH_REQ | RD_PEND | (ACNT!=0) | OUT_VALID.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_COUNT=0, BUSY=0, ACNT=0, RD_PEND=0, FLUSH_REQ=0, ASM=0. FIFO_REN=0 while RST is high.
- Reset mid-operation discards the in-flight word and all partial data.

Test Plan:
1. FIFO preloaded 0x3,0xA,0x5,0xC; OUT_READY=1 -> OUT_DATA 0xA3 then 0xC5, OUT_COUNT=2 each; exactly 4 FIFO_REN pulses; first OUT_VALID 4 cycles after first FIFO_REN.
2. OUT_READY=0; 6 words 0x1..0x6 preloaded -> OUT_DATA 0x21 held stable; FIFO_REN stops after 4 reads. Raise OUT_READY -> 0x43 then 0x65 in order, no loss or duplicate.
3. Single word 0x7, then FLUSH -> OUT_DATA=0x07, OUT_COUNT=1, BUSY drops after acceptance. FLUSH while idle -> no OUT_VALID, BUSY high for 1 cycle only.
4. FLUSH in the same cycle as a pending read of 0x9 (ACNT=0) -> capture lands, then OUT_DATA=0x09, OUT_COUNT=1; no further FIFO_REN until FLUSH_REQ clears.
5. FIFO_EMPTY held 1 for 20 cycles -> FIFO_REN never 1, OUT_VALID stays 0.
6. Assert RST while RD_PEND=1 and ACNT=1 -> all outputs 0 immediately. After release, the next two words pack cleanly with no stale lane data.
